// File: rtl/chip8_alu_sequencer_pkg.sv
// Shared types for the CHIP-8 8XYN sequencer: ALU function codes, sequencer states,
// N-code constants and the decoded per-opcode control word.
package chip8_alu_sequencer_pkg;

    typedef enum logic [3:0] {
        ALU_f_OR     = 4'd0,
        ALU_f_AND    = 4'd1,
        ALU_f_XOR    = 4'd2,
        ALU_f_ADD    = 4'd3,
        ALU_f_MINUS  = 4'd4,
        ALU_f_RSHIFT = 4'd5,
        ALU_f_LSHIFT = 4'd6
    } ALU_f;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_X  = 3'd1;
    localparam logic [2:0] ST_RD_Y  = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_EXEC  = 3'd4;
    localparam logic [2:0] ST_WB_X  = 3'd5;
    localparam logic [2:0] ST_WB_F  = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    localparam logic [3:0] N_LD   = 4'h0;
    localparam logic [3:0] N_OR   = 4'h1;
    localparam logic [3:0] N_AND  = 4'h2;
    localparam logic [3:0] N_XOR  = 4'h3;
    localparam logic [3:0] N_ADD  = 4'h4;
    localparam logic [3:0] N_SUB  = 4'h5;
    localparam logic [3:0] N_SHR  = 4'h6;
    localparam logic [3:0] N_SUBN = 4'h7;
    localparam logic [3:0] N_SHL  = 4'hE;

    typedef enum logic [1:0] {
        FLAG_CARRY  = 2'd0,
        FLAG_VX_LSB = 2'd1,
        FLAG_VX_MSB = 2'd2,
        FLAG_ZERO   = 2'd3
    } flag_src_t;

    typedef struct packed {
        ALU_f      sel;
        logic      swap;      // in1=vy, in2=vx
        logic      shift;     // in2 forced to 1
        logic      zero_in2;  // in2 forced to 0 (plain load)
        flag_src_t flag_src;
        logic      flag_we;
        logic      illegal;
    } op_ctrl_t;

endpackage

// File: rtl/chip8_alu_op_decode.sv
// Combinational decode of the 8XYN N nibble into ALU and write-back controls.
// CHIP8_VF_RESET_EN: OR/AND/XOR also clear VF (COSMAC logic quirk).
module chip8_alu_op_decode
    import chip8_alu_sequencer_pkg::*;
(
    input  logic [3:0] n,
    output op_ctrl_t   ctrl
);

    always_comb begin
        ctrl = '{sel: ALU_f_OR, swap: 1'b0, shift: 1'b0, zero_in2: 1'b0,
                 flag_src: FLAG_CARRY, flag_we: 1'b0, illegal: 1'b0};
        case (n)
            N_LD: begin
                ctrl.swap     = 1'b1;
                ctrl.zero_in2 = 1'b1;
            end
            N_OR:  ctrl.sel = ALU_f_OR;
            N_AND: ctrl.sel = ALU_f_AND;
            N_XOR: ctrl.sel = ALU_f_XOR;
            N_ADD: begin
                ctrl.sel     = ALU_f_ADD;
                ctrl.flag_we = 1'b1;
            end
            N_SUB: begin
                ctrl.sel     = ALU_f_MINUS;
                ctrl.flag_we = 1'b1;
            end
            N_SUBN: begin
                ctrl.sel     = ALU_f_MINUS;
                ctrl.swap    = 1'b1;
                ctrl.flag_we = 1'b1;
            end
            N_SHR: begin
                ctrl.sel      = ALU_f_RSHIFT;
                ctrl.shift    = 1'b1;
                ctrl.flag_src = FLAG_VX_LSB;
                ctrl.flag_we  = 1'b1;
            end
            N_SHL: begin
                ctrl.sel      = ALU_f_LSHIFT;
                ctrl.shift    = 1'b1;
                ctrl.flag_src = FLAG_VX_MSB;
                ctrl.flag_we  = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
`ifdef CHIP8_VF_RESET_EN
        if (n == N_OR || n == N_AND || n == N_XOR) begin
            ctrl.flag_we  = 1'b1;
            ctrl.flag_src = FLAG_ZERO;
        end
`endif
    end

endmodule

// File: rtl/chip8_alu_sequencer.sv
// Executes one CHIP-8 8XYN opcode per start: reads Vx/Vy, drives the external ALU,
// writes Vx then optionally VF. Optional macro CHIP8_VF_RESET_EN (see decoder).
module chip8_alu_sequencer
    import chip8_alu_sequencer_pkg::*;
#(
    parameter logic [3:0] FLAG_REG = 4'hF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] opcode,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [3:0]  reg_addr,
    input  logic [7:0]  reg_rdata,
    output logic        reg_we,
    output logic [7:0]  reg_wdata,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output ALU_f        alu_sel,
    input  logic [15:0] alu_out,
    input  logic        alu_carry
);

    logic [2:0] state_reg, state_next;
    logic [3:0] x_reg, y_reg;
    logic [7:0] vx_reg, vy_reg, res_reg;
    logic       flag_reg, flag_next;
    logic       illegal_reg;
    op_ctrl_t   ctrl_reg, dec_ctrl;
    logic       start_illegal;
    logic       unused_alu_hi;

    assign unused_alu_hi = ^alu_out[15:8];

    chip8_alu_op_decode u_decode (
        .n    (opcode[3:0]),
        .ctrl (dec_ctrl)
    );

    assign start_illegal = (opcode[15:12] != 4'h8) || dec_ctrl.illegal;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = start_illegal ? ST_DONE : ST_RD_X;
            ST_RD_X:  state_next = ST_RD_Y;
            ST_RD_Y:  state_next = ST_LATCH;
            ST_LATCH: state_next = ST_EXEC;
            ST_EXEC:  state_next = ST_WB_X;
            ST_WB_X:  state_next = ctrl_reg.flag_we ? ST_WB_F : ST_DONE;
            ST_WB_F:  state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        flag_next = alu_carry;
        case (ctrl_reg.flag_src)
            FLAG_VX_LSB: flag_next = vx_reg[0];
            FLAG_VX_MSB: flag_next = vx_reg[7];
            FLAG_ZERO:   flag_next = 1'b0;
            default:     flag_next = alu_carry;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            x_reg       <= 4'h0;
            y_reg       <= 4'h0;
            vx_reg      <= 8'h00;
            vy_reg      <= 8'h00;
            res_reg     <= 8'h00;
            flag_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            ctrl_reg    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: if (start) begin
                    x_reg       <= opcode[11:8];
                    y_reg       <= opcode[7:4];
                    ctrl_reg    <= dec_ctrl;
                    illegal_reg <= start_illegal;
                end
                ST_RD_Y:  vx_reg <= reg_rdata;
                ST_LATCH: vy_reg <= reg_rdata;
                ST_EXEC: begin
                    res_reg  <= alu_out[7:0];
                    flag_reg <= flag_next;
                end
                default: ;
            endcase
        end
    end

    // All outputs decode from the registered state; idle/reset gives all-zero with ALU_f_OR.
    always_comb begin
        busy      = (state_reg != ST_IDLE);
        done      = (state_reg == ST_DONE);
        illegal   = (state_reg == ST_DONE) && illegal_reg;
        reg_addr  = 4'h0;
        reg_we    = 1'b0;
        reg_wdata = 8'h00;
        alu_in1   = 16'h0000;
        alu_in2   = 16'h0000;
        alu_sel   = ALU_f_OR;
        case (state_reg)
            ST_RD_X: reg_addr = x_reg;
            ST_RD_Y: reg_addr = y_reg;
            ST_EXEC: begin
                alu_sel = ctrl_reg.sel;
                alu_in1 = {8'h00, (ctrl_reg.swap ? vy_reg : vx_reg)};
                if (ctrl_reg.shift)
                    alu_in2 = 16'h0001;
                else if (!ctrl_reg.zero_in2)
                    alu_in2 = {8'h00, (ctrl_reg.swap ? vx_reg : vy_reg)};
            end
            ST_WB_X: begin
                reg_we    = 1'b1;
                reg_addr  = x_reg;
                reg_wdata = res_reg;
            end
            ST_WB_F: begin
                reg_we    = 1'b1;
                reg_addr  = FLAG_REG;
                reg_wdata = {7'b0, flag_reg};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Directed bench for chip8_alu_sequencer with a behavioural register file and ALU.
module tb_chip8_alu_sequencer;
    import chip8_alu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] opcode = 16'h0000;
    logic        busy, done, illegal, reg_we;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_rdata = 8'h00;
    logic [7:0]  reg_wdata;
    logic [15:0] alu_in1, alu_in2, alu_out;
    logic        alu_carry;
    ALU_f        alu_sel;

    logic [7:0]  rf [16];
    logic        tb_we = 1'b0;
    logic [3:0]  tb_waddr = 4'h0;
    logic [7:0]  tb_wdata = 8'h00;

    int checks = 0;
    int failures = 0;

`ifdef CHIP8_VF_RESET_EN
    localparam int LOGIC_DONE = 7;
    localparam int LOGIC_NWR  = 2;
`else
    localparam int LOGIC_DONE = 6;
    localparam int LOGIC_NWR  = 1;
`endif

    always #5 clk = ~clk;

    chip8_alu_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .opcode    (opcode),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .reg_addr  (reg_addr),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry)
    );

    always @(posedge clk) begin
        if (reg_we)
            rf[reg_addr] <= reg_wdata;
        else if (tb_we)
            rf[tb_waddr] <= tb_wdata;
        reg_rdata <= rf[reg_addr];
    end

    always_comb begin
        logic [16:0] sum;
        sum       = {1'b0, alu_in1} + {1'b0, alu_in2};
        alu_out   = 16'h0000;
        alu_carry = 1'b0;
        case (alu_sel)
            ALU_f_OR:     alu_out = alu_in1 | alu_in2;
            ALU_f_AND:    alu_out = alu_in1 & alu_in2;
            ALU_f_XOR:    alu_out = alu_in1 ^ alu_in2;
            ALU_f_ADD:    begin alu_out = sum[15:0]; alu_carry = (sum[15:0] > 16'h00FF); end
            ALU_f_MINUS:  begin alu_out = alu_in1 - alu_in2; alu_carry = (alu_in1 > alu_in2); end
            ALU_f_RSHIFT: alu_out = alu_in1 >> alu_in2;
            ALU_f_LSHIFT: alu_out = alu_in1 << alu_in2;
            default:      alu_out = 16'h0000;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [15:0] op, input int exp_done,
                          input logic exp_ill, input int exp_nwr,
                          input logic [3:0] a0, input logic [7:0] d0,
                          input logic [3:0] a1, input logic [7:0] d1);
        int         cyc, done_cyc, nwr, wc0;
        logic       ill;
        logic [3:0] wa [2];
        logic [7:0] wd [2];
        done_cyc = -1; nwr = 0; wc0 = -1; ill = 1'b0;
        wa[0] = 4'h0; wa[1] = 4'h0; wd[0] = 8'h00; wd[1] = 8'h00;
        @(negedge clk);
        start = 1'b1; opcode = op;
        @(posedge clk);
        cyc = 0;
        while (done_cyc < 0 && cyc < 20) begin
            @(negedge clk);
            start = 1'b1;       // held high: must be ignored while busy
            opcode = 16'h8124;
            cyc++;
            if (cyc == 1) check_eq({tag, "_busy"}, busy, 1'b1);
            if (reg_we) begin
                if (nwr < 2) begin wa[nwr] = reg_addr; wd[nwr] = reg_wdata; end
                if (nwr == 0) wc0 = cyc;
                nwr++;
            end
            if (done) begin done_cyc = cyc; ill = illegal; end
        end
        start = 1'b0; opcode = 16'h0000;
        check_eq({tag, "_done_cycle"}, done_cyc, exp_done);
        check_eq({tag, "_illegal"}, ill, exp_ill);
        check_eq({tag, "_nwrites"}, nwr, exp_nwr);
        if (exp_nwr >= 1) begin
            check_eq({tag, "_wb_cycle"}, wc0, 5);
            check_eq({tag, "_wr0_addr"}, wa[0], a0);
            check_eq({tag, "_wr0_data"}, wd[0], d0);
        end
        if (exp_nwr >= 2) begin
            check_eq({tag, "_wr1_addr"}, wa[1], a1);
            check_eq({tag, "_wr1_data"}, wd[1], d1);
        end
        @(negedge clk);
        check_eq({tag, "_idle"}, busy, 1'b0);
        $display("op %h: done_cycle=%0d illegal=%0b writes=%0d", op, done_cyc, ill, nwr);
    endtask

    initial begin
        int nwe, ndone;
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_illegal", illegal, 1'b0);
        check_eq("rst_we", reg_we, 1'b0);
        check_eq("rst_addr", reg_addr, 4'h0);
        check_eq("rst_wdata", reg_wdata, 8'h00);
        check_eq("rst_in1", alu_in1, 16'h0);
        check_eq("rst_in2", alu_in2, 16'h0);
        check_eq("rst_sel", alu_sel, ALU_f_OR);
        reset_n = 1'b1;

        set_reg(4'h1, 8'h0F); set_reg(4'h2, 8'hF0); set_reg(4'hF, 8'h55);
        run_op("or", 16'h8121, LOGIC_DONE, 1'b0, LOGIC_NWR, 4'h1, 8'hFF, 4'hF, 8'h00);
        check_eq("or_v1", rf[1], 8'hFF);
`ifdef CHIP8_VF_RESET_EN
        check_eq("or_vf", rf[15], 8'h00);
`else
        check_eq("or_vf", rf[15], 8'h55);
`endif
        run_op("ld", 16'h8120, 6, 1'b0, 1, 4'h1, 8'hF0, 4'h0, 8'h00);

        set_reg(4'h3, 8'hC8); set_reg(4'h4, 8'h64);
        run_op("add", 16'h8344, 7, 1'b0, 2, 4'h3, 8'h2C, 4'hF, 8'h01);

        set_reg(4'h5, 8'h10); set_reg(4'h6, 8'h20);
        run_op("sub", 16'h8565, 7, 1'b0, 2, 4'h5, 8'hF0, 4'hF, 8'h00);
        run_op("subn", 16'h8567, 7, 1'b0, 2, 4'h5, 8'h30, 4'hF, 8'h00);

        set_reg(4'hA, 8'h81);
        run_op("shl", 16'h8A0E, 7, 1'b0, 2, 4'hA, 8'h02, 4'hF, 8'h01);
        set_reg(4'hA, 8'h03);
        run_op("shr", 16'h8A06, 7, 1'b0, 2, 4'hA, 8'h01, 4'hF, 8'h01);

        run_op("ill_n8", 16'h8128, 1, 1'b1, 0, 4'h0, 8'h00, 4'h0, 8'h00);
        run_op("ill_9", 16'h9120, 1, 1'b1, 0, 4'h0, 8'h00, 4'h0, 8'h00);

        set_reg(4'hF, 8'h05); set_reg(4'h5, 8'h01);
        run_op("add_vf", 16'h8F54, 7, 1'b0, 2, 4'hF, 8'h06, 4'hF, 8'h00);
        check_eq("add_vf_final", rf[15], 8'h00);

        // Abort during EXEC: start 8344 then pull reset in cycle 4.
        set_reg(4'h3, 8'h2C);
        @(negedge clk);
        start = 1'b1; opcode = 16'h8344;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        nwe = 0; ndone = 0;
        @(negedge clk);
        check_eq("abort_busy", busy, 1'b0);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (reg_we) nwe++;
            if (done) ndone++;
            @(negedge clk);
        end
        check_eq("abort_we", nwe, 0);
        check_eq("abort_done", ndone, 0);
        check_eq("abort_v3", rf[3], 8'h2C);
        $display("abort: writes=%0d dones=%0d", nwe, ndone);

        set_reg(4'h1, 8'hA5);
        run_op("xor", 16'h8123, LOGIC_DONE, 1'b0, LOGIC_NWR, 4'h1, 8'h55, 4'hF, 8'h00);
        check_eq("xor_v1", rf[1], 8'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
